// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete at the accepting edge; MUL iterates one shift-add step per cycle.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_XOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_NOT = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_SLA = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_SLT = 4'd10;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t                 state_reg, state_next;
    logic [2*WIDTH-1:0]     mcand_reg, acc_reg;
    logic [WIDTH-1:0]       mplier_reg;
    logic [CW-1:0]          step_reg;

    logic                   accept, load_op, mul_done, out_free;
    logic [SHW-1:0]         sh;
    logic [WIDTH-1:0]       op_res;
    logic                   op_carry, op_ovf, op_err;
    logic [3:0]             op_flags;
    logic [2*WIDTH-1:0]     acc_step, product;
    logic [3:0]             mul_flags;

    // Single-cycle datapath
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_err   = 1'b0;
        sh       = b[SHW-1:0];
        case (select)
            OP_ADD: begin
                {op_carry, op_res} = {1'b0, a} + {1'b0, b};
                op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                {op_carry, op_res} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: op_res = a ^ b;
            OP_NOT: op_res = ~a;
            OP_OR:  op_res = a | b;
            OP_AND: op_res = a & b;
            OP_SLA: op_res = a << sh;
            OP_SRA: op_res = $signed(a) >>> sh;
            OP_SRL: op_res = a >> sh;
            OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL: op_res = '0;
            default: op_err = 1'b1;
        endcase
        op_flags = op_err ? 4'b0000
                          : {op_ovf, op_carry, op_res[WIDTH-1], (op_res == '0)};
    end

    // Last step folds into the product combinationally so the result loads at edge E+WIDTH
    always_comb begin
        acc_step  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        product   = (step_reg == CW'(WIDTH)) ? acc_reg : acc_step;
        mul_flags = {1'b0, (product[2*WIDTH-1:WIDTH] != '0), product[WIDTH-1],
                     (product[WIDTH-1:0] == '0)};
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept && select == OP_MUL) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_free = !out_valid || out_ready;
        in_ready = (state_reg == IDLE) && out_free;
        accept   = in_valid && in_ready;
        load_op  = accept && (select != OP_MUL);
        mul_done = (state_reg == MUL_BUSY) && (step_reg >= CW'(WIDTH - 1)) && out_free;
    end

    // Multiplier: counter saturates at WIDTH while the output register is occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            step_reg   <= '0;
        end else if (accept && select == OP_MUL) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            step_reg   <= '0;
        end else if (state_reg == MUL_BUSY && step_reg != CW'(WIDTH)) begin
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            step_reg   <= step_reg + CW'(1);
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else if (load_op) begin
            out_valid <= 1'b1;
            alu_out   <= op_res;
            flags     <= op_flags;
            err       <= op_err;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            alu_out   <= product[WIDTH-1:0];
            flags     <= mul_flags;
            err       <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the 32-bit combinational datapath ALU. It registers every result, adds a status-flag output, and supports multi-bit shifts (by up to WIDTH-1 positions) and an iterative unsigned multiply. It sits between operand fetch and writeback in the execute stage, using valid/ready flow control on both sides so that multi-cycle operations can stall the pipeline.

## Interface
- WIDTH, 32, datapath width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shifts use b[SHW-1:0] only.
- select  in  4  opcode.
- out_valid  out  1  result/flags held valid.
- out_ready  in  1  consumer takes result this cycle.
- alu_out  out  WIDTH  result.
- flags  out  4  {ovf, carry, neg, zero}.
- err  out  1  opcode illegal (11..15).

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 XOR.
  - 2 SUB: a+~b+1.
  - 3 NOT a.
  - 4 OR.
  - 5 AND.
  - 6 SLA: a<<sh.
  - 7 SRA: arithmetic a>>>sh.
  - 8 SRL: a>>sh.
  - 9 MUL: low WIDTH bits of unsigned a*b.
  - 10 SLT: signed a<b, giving result 1 or 0.
  - 11..15: result 0, err=1, flags 0.
- sh = b[SHW-1:0]. sh=0 passes a unchanged.
- Flags are computed on the WIDTH-bit result:
  - zero = (result==0).
  - neg = result[WIDTH-1].
  - carry:
    - ADD: carry-out.
    - SUB: carry-out of a+~b+1, i.e. 1 = no borrow.
    - MUL: 1 if the upper WIDTH bits of the full product are non-zero.
    - Otherwise 0.
  - ovf: signed overflow for ADD/SUB; 0 otherwise.
- State machine IDLE / MUL_BUSY:
  - IDLE: an accept (in_valid && in_ready) of a non-MUL op loads alu_out/flags/err and sets out_valid at the edge.
  - IDLE: an accept of MUL latches a, b, clears the accumulator and counter, and moves to MUL_BUSY.
  - MUL_BUSY: one shift-add step per cycle (LSB of the multiplier). After WIDTH steps it loads the output register, sets out_valid, and returns to IDLE.
- Operands on a/b/select are sampled only on accept; changes while busy are ignored.
- Output register:
  - Holds alu_out/flags/err stable while out_valid && !out_ready.
  - Clears out_valid on out_ready, unless a new result loads in the same edge.

## Timing
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from out_ready; there is no combinational path from in_valid.
- Single-cycle ops: accept at edge E, so out_valid=1 after E. Back-to-back throughput is 1 per cycle while out_ready=1.
- MUL: accept at edge E, so out_valid=1 after edge E+WIDTH. in_ready=0 during the WIDTH busy cycles.
- Simultaneous out_ready and new accept in the same cycle: the old result retires and the new one loads. out_valid stays 1 and nothing is lost or duplicated.
- Backpressure with out_valid=1 and out_ready=0: in_ready=0. A MUL completion waiting on a full output register stays in MUL_BUSY with the step counter saturated, and loads on the first cycle the register frees.
- Reset values (async on rst_n low, effective immediately):
  - state=IDLE, step counter 0, multiplier registers 0.
  - out_valid=0, alu_out=0, flags=0, err=0.
  - in_ready=1 once rst_n is high.
- Reset asserted mid-MUL aborts the multiply; no result is emitted after release.

## Test plan
- WIDTH=32: ADD a=0x7FFFFFFF, b=1, out_ready=1 → after 1 edge: alu_out=0x80000000, flags ovf=1, carry=0, neg=1, zero=0.
- SUB a=5, b=5 → alu_out=0, zero=1, carry=1. SUB a=0, b=1 → 0xFFFFFFFF, carry=0, neg=1.
- Shifts with a=0x80000010, b=4:
  - SLA → 0x00000100.
  - SRA → 0xF8000001.
  - SRL → 0x08000001.
  - Any of them with b=0x25 uses sh=5.
- MUL a=0x00010000, b=0x00010000 → out_valid exactly 32 edges after accept, alu_out=0, carry=1, zero=1, in_ready=0 throughout. MUL 7*6 → 42, carry=0.
- Stream ADD ops 1+1, 2+2, 3+3 with out_ready held low for 3 cycles, then high:
  - First result 2 stays stable.
  - in_ready stays 0.
  - Results then arrive 2, 4, 6 with no loss or duplication.
- select=12 → alu_out=0, err=1. Assert rst_n=0 at busy step 10 of a MUL → out_valid=0 immediately, in_ready=1 after release, no stray result.
